aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencer for the 16-byte AES state memory (data_Mem). It loads a plaintext block with the initial AddRoundKey applied, then drives NR rounds of SubBytes, ShiftRows, MixColumns and AddRoundKey through the memory's CS/RWSM/Add/DataIN/DataOUT port. It then streams the 16 ciphertext bytes out. S-box and round-key storage are external; this block only schedules them.

Parameters:
NR, 10, number of rounds; legal range 1..14; MixColumns is skipped in round NR.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous active-low reset
Start  in  1  pulse; begins a block when idle
In_Valid  in  1  plaintext byte valid
In_Data  in  8  plaintext byte; byte k goes to address k
In_Ready  out  1  high only in LOAD
Key_Round  out  4  round index of requested key byte
Key_Addr  out  4  byte index of requested key byte
Key_Data  in  8  key byte, combinational response to Key_Round/Key_Addr
Sb_In  out  8  S-box lookup input
Sb_Out  in  8  S-box lookup result, combinational
Mem_CS  out  1  to data_Mem CS
Mem_RWSM  out  2  to data_Mem RWSM: 00 read, 01 write, 10 shift, 11 mix
Mem_Add  out  4  to data_Mem Add
Mem_DataIN  out  8  to data_Mem DataIN
Mem_DataOUT  in  8  from data_Mem DataOUT
Out_Valid  out  1  ciphertext byte valid
Out_Data  out  8  ciphertext byte, address order 0..15
Out_Ready  in  1  consumer accepts byte
Busy  out  1  high in every state except IDLE
Round_Cnt  out  4  current round; 0 during LOAD

Behaviour:
- Memory contract: a read (CS=1, RWSM=00) registers mem[Add] onto DataOUT at the edge. DataOUT holds until the next read. Write, shift and mix each take effect at the edge. CS=0 means no operation.
- Reset: state IDLE; idx=0; Round_Cnt=0. Mem_CS, Mem_RWSM, Mem_Add, Mem_DataIN, In_Ready, Out_Valid, Out_Data, Busy, Key_* and Sb_In are all 0. Reset mid-block abandons the block; memory contents are then undefined.
- Mem_CS=0 in every state not listed below as issuing an operation.
- IDLE: Start=1 -> LOAD with idx=0. In_Valid is ignored outside LOAD. Start is ignored outside IDLE.
- LOAD: In_Ready=1; Key_Round=0, Key_Addr=idx.
  - On In_Valid: write In_Data^Key_Data to address idx (CS=1, RWSM=01), then idx++.
  - After idx 15 the block goes to SUB_RD with Round_Cnt=1, idx=0.
  - Gaps in In_Valid stall the load with no memory operation.
- SUB_RD: read idx. SUB_WR: Sb_In=Mem_DataOUT; write Sb_Out to idx. Then SUB_RD at idx+1, or SHIFT after idx 15.
- SHIFT: one cycle, RWSM=10. Next state is MIX if Round_Cnt<NR, otherwise ARK_RD.
- MIX: one cycle, RWSM=11. Next state ARK_RD.
- ARK_RD: read idx; Key_Round=Round_Cnt, Key_Addr=idx. ARK_WR: write Mem_DataOUT^Key_Data to idx.
- After ARK_WR at idx 15:
  - Round_Cnt<NR: Round_Cnt++ and go to SUB_RD.
  - Round_Cnt=NR: go to OUT_RD with idx=0.
- idx wraps 15->0 at the end of every pass.
- OUT_RD: read idx. OUT_VLD: Out_Valid=1, Out_Data=Mem_DataOUT.
  - Hold in OUT_VLD while Out_Ready=0.
  - On Out_Ready=1: byte accepted. Go to OUT_RD at idx+1, or to IDLE after idx 15.
- Out_Data is 0 whenever Out_Valid=0.
- Latency from the last LOAD byte to the first Out_Valid:
  - per non-final round: 66 cycles (32 SUB + SHIFT + MIX + 32 ARK);
  - final round: 65 cycles;
  - plus 1 cycle for OUT_RD.
  - NR=10: 9*66+65+1 = 660 cycles.
- Busy deasserts in the cycle after the last byte is accepted. Start may be accepted in that same cycle.

Test Plan:
- Reset mid-SUB pass (RST low for 1 cycle) -> all outputs 0 and state IDLE while RST is low; a new Start then completes a correct block.
- FIPS-197 C.1 with NR=10, key 000102..0f, plaintext 00112233445566778899aabbccddeeff, behavioural data_Mem, S-box and key expansion -> Out bytes 69c4e0d86a7b0430d8cdb78070b4c55a; first Out_Valid exactly 660 cycles after the 16th In_Valid.
- NR=1 -> exactly one RWSM=10 and zero RWSM=11 cycles; Round_Cnt never exceeds 1; first Out_Valid 66 cycles after the last load byte.
- In_Valid toggling 1/0 during LOAD -> exactly 16 writes at addresses 0..15 in order; no write in gap cycles.
- Out_Ready held low 5 cycles on byte 3 -> Out_Valid and Out_Data stable for those cycles; Mem_CS=0 throughout the stall.
- Start pulsed during a SUB pass and In_Valid pulsed during rounds -> no effect on sequencing or output; Busy=1 continuously until byte 15 is accepted.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Sequencer for a 16-byte AES state memory (data_Mem). A block is processed
// in three phases:
//   1. LOAD   : plaintext bytes arrive on In_Valid/In_Data. Each byte is XORed
//               with round-0 key byte idx and written to address idx, which
//               applies the initial AddRoundKey during the load.
//   2. ROUNDS : NR rounds. Each round is a SubBytes pass (read/write per byte),
//               one ShiftRows cycle, one MixColumns cycle (skipped in round NR)
//               and an AddRoundKey pass (read/write per byte).
//   3. OUTPUT : the 16 ciphertext bytes are read back in address order and
//               handed out with a valid/ready handshake.
// The S-box and round-key storage are external combinational lookups.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   Start           begins a block when idle
//   In_Valid/In_Data/In_Ready     plaintext byte stream (In_Ready only in LOAD)
//   Key_Round/Key_Addr/Key_Data   round-key byte lookup
//   Sb_In/Sb_Out                  S-box lookup
//   Mem_CS/Mem_RWSM/Mem_Add/Mem_DataIN/Mem_DataOUT   data_Mem port
//                                 RWSM: 00 read, 01 write, 10 shift, 11 mix
//   Out_Valid/Out_Data/Out_Ready  ciphertext byte stream, address order 0..15
//   Busy            high in every state except IDLE
//   Round_Cnt       current round, 0 during LOAD
//
// Parameter NR (number of rounds) must lie in 1..14.
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       In_Valid,
  input  logic [7:0] In_Data,
  output logic       In_Ready,
  output logic [3:0] Key_Round,
  output logic [3:0] Key_Addr,
  input  logic [7:0] Key_Data,
  output logic [7:0] Sb_In,
  input  logic [7:0] Sb_Out,
  output logic       Mem_CS,
  output logic [1:0] Mem_RWSM,
  output logic [3:0] Mem_Add,
  output logic [7:0] Mem_DataIN,
  input  logic [7:0] Mem_DataOUT,
  output logic       Out_Valid,
  output logic [7:0] Out_Data,
  input  logic       Out_Ready,
  output logic       Busy,
  output logic [3:0] Round_Cnt
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] LAST_IDX   = 4'd15;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_MIX   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_SUB_RD  = 4'd2,
    S_SUB_WR  = 4'd3,
    S_SHIFT   = 4'd4,
    S_MIX     = 4'd5,
    S_ARK_RD  = 4'd6,
    S_ARK_WR  = 4'd7,
    S_OUT_RD  = 4'd8,
    S_OUT_VLD = 4'd9
  } state_t;

  state_t     state_reg;
  logic [3:0] idx_reg;
  logic [3:0] round_reg;

  // ---------------------------------------------------------------------------
  // Sequencing. idx_reg is a 4-bit counter, so every pass wraps 15 -> 0 by
  // itself and the next pass always starts at address 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      round_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            state_reg <= S_LOAD;
            idx_reg   <= '0;
            round_reg <= '0;
          end
        end

        S_LOAD: begin
          // Gaps in In_Valid simply stall here.
          if (In_Valid) begin
            idx_reg <= idx_reg + 4'd1;
            if (idx_reg == LAST_IDX) begin
              state_reg <= S_SUB_RD;
              round_reg <= 4'd1;
            end
          end
        end

        S_SUB_RD: state_reg <= S_SUB_WR;

        S_SUB_WR: begin
          idx_reg   <= idx_reg + 4'd1;
          state_reg <= (idx_reg == LAST_IDX) ? S_SHIFT : S_SUB_RD;
        end

        // The final round has no MixColumns.
        S_SHIFT: state_reg <= (round_reg < LAST_ROUND) ? S_MIX : S_ARK_RD;

        S_MIX: state_reg <= S_ARK_RD;

        S_ARK_RD: state_reg <= S_ARK_WR;

        S_ARK_WR: begin
          idx_reg <= idx_reg + 4'd1;
          if (idx_reg == LAST_IDX) begin
            if (round_reg < LAST_ROUND) begin
              round_reg <= round_reg + 4'd1;
              state_reg <= S_SUB_RD;
            end else begin
              state_reg <= S_OUT_RD;
            end
          end else begin
            state_reg <= S_ARK_RD;
          end
        end

        S_OUT_RD: state_reg <= S_OUT_VLD;

        S_OUT_VLD: begin
          if (Out_Ready) begin
            idx_reg <= idx_reg + 4'd1;
            if (idx_reg == LAST_IDX) begin
              state_reg <= S_IDLE;
              round_reg <= '0;
            end else begin
              state_reg <= S_OUT_RD;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
          idx_reg   <= '0;
          round_reg <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the registered state. Everything is a function of
  // state_reg/idx_reg/round_reg except the LOAD write, which must follow
  // In_Valid in the same cycle, and the data paths that combine the
  // combinational key/S-box responses with Mem_DataOUT. Mem_DataOUT holds its
  // last read value, so it is safe to use in the cycle after each read.
  // ---------------------------------------------------------------------------
  always_comb begin
    In_Ready   = 1'b0;
    Key_Round  = '0;
    Key_Addr   = '0;
    Sb_In      = '0;
    Mem_CS     = 1'b0;
    Mem_RWSM   = OP_READ;
    Mem_Add    = '0;
    Mem_DataIN = '0;
    Out_Valid  = 1'b0;
    Out_Data   = '0;

    case (state_reg)
      S_LOAD: begin
        In_Ready = 1'b1;
        Key_Addr = idx_reg;
        if (In_Valid) begin
          Mem_CS     = 1'b1;
          Mem_RWSM   = OP_WRITE;
          Mem_Add    = idx_reg;
          Mem_DataIN = In_Data ^ Key_Data;
        end
      end

      S_SUB_RD: begin
        Mem_CS   = 1'b1;
        Mem_RWSM = OP_READ;
        Mem_Add  = idx_reg;
      end

      S_SUB_WR: begin
        Sb_In      = Mem_DataOUT;
        Mem_CS     = 1'b1;
        Mem_RWSM   = OP_WRITE;
        Mem_Add    = idx_reg;
        Mem_DataIN = Sb_Out;
      end

      S_SHIFT: begin
        Mem_CS   = 1'b1;
        Mem_RWSM = OP_SHIFT;
      end

      S_MIX: begin
        Mem_CS   = 1'b1;
        Mem_RWSM = OP_MIX;
      end

      S_ARK_RD: begin
        Key_Round = round_reg;
        Key_Addr  = idx_reg;
        Mem_CS    = 1'b1;
        Mem_RWSM  = OP_READ;
        Mem_Add   = idx_reg;
      end

      // Key lookup stays pointed at the same byte so Key_Data is valid here.
      S_ARK_WR: begin
        Key_Round  = round_reg;
        Key_Addr   = idx_reg;
        Mem_CS     = 1'b1;
        Mem_RWSM   = OP_WRITE;
        Mem_Add    = idx_reg;
        Mem_DataIN = Mem_DataOUT ^ Key_Data;
      end

      S_OUT_RD: begin
        Mem_CS   = 1'b1;
        Mem_RWSM = OP_READ;
        Mem_Add  = idx_reg;
      end

      // No memory access while waiting, so the read data stays put.
      S_OUT_VLD: begin
        Out_Valid = 1'b1;
        Out_Data  = Mem_DataOUT;
      end

      default: ;
    endcase
  end

  assign Busy      = (state_reg != S_IDLE);
  assign Round_Cnt = round_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Two sequencers share one clock: dut0 with NR=10 and dut1 with NR=1. Each has
// its own behavioural data_Mem, and both share an S-box table and an AES-128
// key schedule (key 000102..0f) built at time zero. Expected ciphertexts are
// FIPS-197 C.1 values (full cipher, and the round-1 state without MixColumns
// for the single-round case).
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v       [2];
  logic       start_v     [2];
  logic       in_valid_v  [2];
  logic [7:0] in_data_v   [2];
  logic       in_ready_v  [2];
  logic [3:0] key_round_v [2];
  logic [3:0] key_addr_v  [2];
  logic [7:0] key_data_v  [2];
  logic [7:0] sb_in_v     [2];
  logic [7:0] sb_out_v    [2];
  logic       mem_cs_v    [2];
  logic [1:0] mem_rwsm_v  [2];
  logic [3:0] mem_add_v   [2];
  logic [7:0] mem_din_v   [2];
  logic [7:0] mem_dout_v  [2];
  logic       out_valid_v [2];
  logic [7:0] out_data_v  [2];
  logic       out_ready_v [2];
  logic       busy_v      [2];
  logic [3:0] round_cnt_v [2];

  aes_round_ctrl #(.NR(10)) dut0 (
    .CLK(clk), .RST(rst_v[0]), .Start(start_v[0]),
    .In_Valid(in_valid_v[0]), .In_Data(in_data_v[0]), .In_Ready(in_ready_v[0]),
    .Key_Round(key_round_v[0]), .Key_Addr(key_addr_v[0]), .Key_Data(key_data_v[0]),
    .Sb_In(sb_in_v[0]), .Sb_Out(sb_out_v[0]),
    .Mem_CS(mem_cs_v[0]), .Mem_RWSM(mem_rwsm_v[0]), .Mem_Add(mem_add_v[0]),
    .Mem_DataIN(mem_din_v[0]), .Mem_DataOUT(mem_dout_v[0]),
    .Out_Valid(out_valid_v[0]), .Out_Data(out_data_v[0]), .Out_Ready(out_ready_v[0]),
    .Busy(busy_v[0]), .Round_Cnt(round_cnt_v[0])
  );

  aes_round_ctrl #(.NR(1)) dut1 (
    .CLK(clk), .RST(rst_v[1]), .Start(start_v[1]),
    .In_Valid(in_valid_v[1]), .In_Data(in_data_v[1]), .In_Ready(in_ready_v[1]),
    .Key_Round(key_round_v[1]), .Key_Addr(key_addr_v[1]), .Key_Data(key_data_v[1]),
    .Sb_In(sb_in_v[1]), .Sb_Out(sb_out_v[1]),
    .Mem_CS(mem_cs_v[1]), .Mem_RWSM(mem_rwsm_v[1]), .Mem_Add(mem_add_v[1]),
    .Mem_DataIN(mem_din_v[1]), .Mem_DataOUT(mem_dout_v[1]),
    .Out_Valid(out_valid_v[1]), .Out_Data(out_data_v[1]), .Out_Ready(out_ready_v[1]),
    .Busy(busy_v[1]), .Round_Cnt(round_cnt_v[1])
  );

  // ---------------- environment: S-box, key schedule, data_Mem ----------------
  logic [7:0]   sbox_t [256];
  logic [127:0] rk     [15];   // rk[r], byte k at bits [8k+:8]
  logic [127:0] mem_v  [2];    // byte k at bits [8k+:8], column-major state

  assign key_data_v[0] = rk[key_round_v[0]][8*key_addr_v[0] +: 8];
  assign key_data_v[1] = rk[key_round_v[1]][8*key_addr_v[1] +: 8];
  assign sb_out_v[0]   = sbox_t[sb_in_v[0]];
  assign sb_out_v[1]   = sbox_t[sb_in_v[1]];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c)   +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[8*(4*c+3) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (mem_cs_v[n]) begin
        case (mem_rwsm_v[n])
          2'b00: mem_dout_v[n] <= mem_v[n][8*mem_add_v[n] +: 8];
          2'b01: mem_v[n][8*mem_add_v[n] +: 8] <= mem_din_v[n];
          2'b10: mem_v[n] <= shift_rows(mem_v[n]);
          default: mem_v[n] <= mix_cols(mem_v[n]);
        endcase
      end
    end
  end

  // ---------------- per-cycle monitors ----------------
  int   tests_run, tests_failed;
  int   shift_cnt [2], mix_cnt [2], max_round [2], busy_drop [2];
  int   wr_cnt [2], wr_err [2], gap_wr [2];
  logic busy_mon [2];

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (mem_cs_v[n] && mem_rwsm_v[n] == 2'b10) shift_cnt[n]++;
      if (mem_cs_v[n] && mem_rwsm_v[n] == 2'b11) mix_cnt[n]++;
      if (int'(round_cnt_v[n]) > max_round[n]) max_round[n] = int'(round_cnt_v[n]);
      if (busy_mon[n] && !busy_v[n]) busy_drop[n]++;
      // LOAD writes: plaintext byte k is k*0x11, round-0 key byte k is k.
      if (in_ready_v[n]) begin
        if (mem_cs_v[n] && mem_rwsm_v[n] == 2'b01) begin
          if (!in_valid_v[n]) gap_wr[n]++;
          if (mem_add_v[n] != 4'(wr_cnt[n]) ||
              mem_din_v[n] != (8'(wr_cnt[n] * 17) ^ 8'(wr_cnt[n])))
            wr_err[n]++;
          wr_cnt[n]++;
        end else if (in_valid_v[n]) begin
          wr_err[n]++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [45:0] all_outs(input int n);
    return {in_ready_v[n], out_valid_v[n], out_data_v[n], busy_v[n], round_cnt_v[n],
            key_round_v[n], key_addr_v[n], sb_in_v[n], mem_cs_v[n], mem_rwsm_v[n],
            mem_add_v[n], mem_din_v[n]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_block(input int n, input bit toggle);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_data_v[n]  = 8'(k * 17);
      in_valid_v[n] = 1'b1;
      if (toggle && k < 15) begin
        @(negedge clk);
        in_valid_v[n] = 1'b0;
      end
    end
  endtask

  task automatic read_out(input int n, input bit stall, output logic [127:0] got,
                          output int nbytes, output int unstable, output int stall_cs);
    int guard = 0;
    logic [7:0] b;
    got = '0; nbytes = 0; unstable = 0; stall_cs = 0;
    while (nbytes < 16 && guard < 400) begin
      if (out_valid_v[n]) begin
        b = out_data_v[n];
        if (stall && nbytes == 3) begin
          out_ready_v[n] = 1'b0;
          repeat (5) begin
            @(negedge clk);
            if (!out_valid_v[n] || out_data_v[n] != b) unstable++;
            if (mem_cs_v[n]) stall_cs++;
          end
          out_ready_v[n] = 1'b1;
        end
        got[127-8*nbytes -: 8] = b;
        nbytes++;
      end
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_block(input int n, input bit toggle, input bit disturb, input int nr,
                           input int exp_lat, input logic [127:0] exp_ct, input string name);
    int cyc, nbytes, unstable, stall_cs;
    logic [127:0] got;
    shift_cnt[n] = 0; mix_cnt[n] = 0; max_round[n] = 0; busy_drop[n] = 0;
    wr_cnt[n] = 0; wr_err[n] = 0; gap_wr[n] = 0;
    start_v[n] = 1'b1;
    @(negedge clk);
    start_v[n] = 1'b0;
    busy_mon[n] = 1'b1;
    check({name, "_load_entry"}, {in_ready_v[n], busy_v[n], round_cnt_v[n]}, {1'b1, 1'b1, 4'd0});
    load_block(n, toggle);
    // cyc counts edges from the one that captures the last plaintext byte.
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) in_valid_v[n] = 1'b0;
      if (disturb) begin
        case (cyc)
          20:  start_v[n] = 1'b1;
          21:  start_v[n] = 1'b0;
          300: begin in_valid_v[n] = 1'b1; in_data_v[n] = 8'hff; end
          301: in_valid_v[n] = 1'b0;
          default: ;
        endcase
      end
    end while (!out_valid_v[n] && cyc < 2000);
    check({name, "_latency"}, cyc - 1, exp_lat);
    read_out(n, disturb, got, nbytes, unstable, stall_cs);
    busy_mon[n] = 1'b0;
    check({name, "_out_bytes"}, nbytes, 16);
    check({name, "_busy_after"}, busy_v[n], 1'b0);
    check({name, "_cipher"}, got, exp_ct);
    check({name, "_busy_drops"}, busy_drop[n], 0);
    check({name, "_load_writes"}, wr_cnt[n], 16);
    check({name, "_load_order_err"}, wr_err[n], 0);
    check({name, "_gap_writes"}, gap_wr[n], 0);
    check({name, "_shift_cycles"}, shift_cnt[n], nr);
    check({name, "_mix_cycles"}, mix_cnt[n], nr - 1);
    check({name, "_max_round"}, max_round[n], nr);
    if (disturb) begin
      check({name, "_stall_unstable"}, unstable, 0);
      check({name, "_stall_mem_cs"}, stall_cs, 0);
    end
    $display("[TB] %s: dut%0d ciphertext %h latency %0d", name, n, got, cyc - 1);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] CT_NR10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_NR1  = 128'hb5f99471dbcf93fe17d6cfa06c61a619;

  initial begin
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon, inv;
    logic [127:0] key;

    // S-box: multiplicative inverse followed by the affine transform.
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_t[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    // AES-128 key expansion.
    key  = 128'h000102030405060708090a0b0c0d0e0f;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      rk[r] = '0;
      if (r < 11)
        for (int k = 0; k < 16; k++) rk[r][8*k +: 8] = w[4*r + k/4][31-8*(k%4) -: 8];
    end

    tests_run = 0; tests_failed = 0;
    for (int n = 0; n < 2; n++) begin
      rst_v[n] = 1'b0; start_v[n] = 1'b0; in_valid_v[n] = 1'b0; in_data_v[n] = 8'h00;
      out_ready_v[n] = 1'b1; busy_mon[n] = 1'b0; mem_dout_v[n] = 8'h00; mem_v[n] = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_outputs_dut0", all_outs(0), 46'h0);
    check("reset_outputs_dut1", all_outs(1), 46'h0);
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    @(negedge clk);
    check("idle_no_busy", busy_v[0], 1'b0);

    // Toggled load, Start/In_Valid noise during rounds, output stall on byte 3.
    run_block(0, 1'b1, 1'b1, 10, 660, CT_NR10, "c1_nr10");

    // Reset in the middle of the first SubBytes pass.
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    load_block(0, 1'b0);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_round", round_cnt_v[0], 4'd1);
    rst_v[0] = 1'b0;
    #1;
    check("mid_reset_outputs", all_outs(0), 46'h0);
    @(negedge clk);
    check("mid_reset_held", all_outs(0), 46'h0);
    rst_v[0] = 1'b1;
    @(negedge clk);
    run_block(0, 1'b0, 1'b0, 10, 660, CT_NR10, "after_reset");

    // Single-round instance.
    run_block(1, 1'b0, 1'b0, 1, 66, CT_NR1, "nr1");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
